teatris_unidade_controle: RTL and testbench
===========================================

Name: teatris_unidade_controle

Overview:
Moore-style control unit that sequences the TEAtris datapath through one game round. It handles the start/restart handshake, piece/map loading, player-move capture and comparison, success and error animations, and the per-error and timeout accounting. It terminates in a win or loss display that shows the end map. It sits beside the datapath: it consumes the datapath status flags and drives every datapath control strobe.

Parameters:
MAX_ERROS, 3, number of accumulated errors (datapath `erros` value) that ends the game as a loss; legal range 1..15.

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-high; forces state INICIAL
iniciar  input  1  start/restart request, level-sampled
tem_jogada  input  1  one-cycle pulse, button press detected
jogada_ok  input  1  registered move equals expected move
fim_sequencia  input  1  address counter at last entry (15)
timeout  input  1  move timer expired
fim_timer_animacao  input  1  animation timer expired
fim_erro  input  1  error counter at 15
erros  input  4  current error count
zera_contador  output  1  clear address counter
conta_contador  output  1  increment address counter
enable_memoria  output  1  load piece/map/column registers
registra_jogada  output  1  capture buttons into move register
zera_jogada  output  1  clear move register
timer_restart  output  1  restart move timer
timer_animacao_restart  output  1  restart animation timer
conta_timer_animacao  output  1  enable animation timer
zera_erro  output  1  clear error counter
conta_erro  output  1  increment error counter
mapa_fim  output  1  select end-of-game map source
pronto  output  1  idle / awaiting start
ganhou  output  1  win indication
perdeu  output  1  loss indication
db_estado  output  4  current state code

Behaviour:
- Moore outputs, decoded from the state register only. Every output not listed for a state is 0. After reset: state INICIAL, pronto=1, all other outputs 0, db_estado=0.
- Each state below lists: code, outputs asserted, and next state.
- INICIAL (0): pronto. Goes to PREPARA if iniciar=1, otherwise stays.
- PREPARA (1): zera_contador, zera_erro, zera_jogada, timer_restart, timer_animacao_restart. Goes to AGUARDA_ROM.
- AGUARDA_ROM (2): no outputs. One cycle for the synchronous ROM read at the new address. Goes to CARREGA.
- CARREGA (3): enable_memoria, timer_restart. Goes to ESPERA.
- ESPERA (4): no outputs. Exits in priority order:
  - timeout=1: go to CONTA_ERRO. Timeout wins over a simultaneous tem_jogada.
  - tem_jogada=1: go to REGISTRA.
  - otherwise stay.
- REGISTRA (5): registra_jogada. Goes to COMPARA.
- COMPARA (6): timer_animacao_restart. Goes to ANIMA_ACERTO if jogada_ok=1, otherwise CONTA_ERRO.
- ANIMA_ACERTO (7): conta_timer_animacao. On fim_timer_animacao=1:
  - fim_sequencia=1: go to FIM_GANHOU.
  - otherwise go to PROXIMA.
- PROXIMA (8): conta_contador, zera_jogada. Goes to AGUARDA_ROM.
- CONTA_ERRO (9): conta_erro, zera_jogada, timer_animacao_restart. Goes to ANIMA_ERRO.
- ANIMA_ERRO (10): conta_timer_animacao. On fim_timer_animacao=1:
  - (erros >= MAX_ERROS) or fim_erro=1: go to FIM_PERDEU.
  - otherwise go to CARREGA, which retries the same address; it is not re-incremented.
- FIM_GANHOU (11): mapa_fim, enable_memoria, ganhou. Goes to PREPARA if iniciar=1, otherwise stays.
- FIM_PERDEU (12): mapa_fim, enable_memoria, perdeu. Goes to PREPARA if iniciar=1, otherwise stays.
- Latency: exactly 2 clocks from tem_jogada sampled in ESPERA to the COMPARA decision.
- The address-increment-to-register-load path is 3 clocks: PROXIMA, then AGUARDA_ROM, then CARREGA.
- `erros` is evaluated in ANIMA_ERRO, i.e. after the increment issued in CONTA_ERRO has taken effect.
- tem_jogada, timeout and fim_timer_animacao are ignored in every state where they are not listed.
- iniciar is ignored outside INICIAL, FIM_GANHOU and FIM_PERDEU.
- Unused codes 13–15 go to INICIAL on the next clock.
- Asserting reset in any state, including mid-animation, returns the block to INICIAL asynchronously. Outputs take their reset values immediately.

Test Plan:
- Reset then iniciar=1 for 1 cycle: db_estado sequence 0,1,2,3,4. zera_contador, zera_erro and timer_restart are high in code 1; enable_memoria is high in code 3.
- In ESPERA, pulse tem_jogada with jogada_ok=1 and fim_sequencia=0, then fim_timer_animacao after 5 cycles. Required: states 5,6,7,…,8,2,3,4; conta_contador high exactly 1 cycle.
- In ESPERA, pulse tem_jogada with jogada_ok=0 and erros=1 after increment, then fim_timer_animacao. Required: states 5,6,9,10,3,4; conta_erro high exactly 1 cycle; no conta_contador.
- In ESPERA, assert timeout and tem_jogada in the same cycle. Required: next state 9, not 5.
- With MAX_ERROS=3, drive erros=3 during ANIMA_ERRO, then fim_timer_animacao. Required: state 12; perdeu=1, mapa_fim=1, enable_memoria=1. Then iniciar=1 gives state 1.
- With fim_sequencia=1 in ANIMA_ACERTO and fim_timer_animacao=1: state 11, ganhou=1. Asserting reset mid-ANIMA_ERRO gives db_estado=0 and pronto=1 without a clock edge.

Source files
------------

// File: rtl/teatris_unidade_controle.sv
`default_nettype none
// ============================================================================
// Module  : teatris_unidade_controle
// Purpose : Moore control unit that sequences one TEAtris game round.
// Rev     : 1.0  initial release
// ============================================================================
module teatris_unidade_controle #(
   parameter int MAX_ERROS = 3
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       iniciar,
   input  logic       tem_jogada,
   input  logic       jogada_ok,
   input  logic       fim_sequencia,
   input  logic       timeout,
   input  logic       fim_timer_animacao,
   input  logic       fim_erro,
   input  logic [3:0] erros,
   output logic       zera_contador,
   output logic       conta_contador,
   output logic       enable_memoria,
   output logic       registra_jogada,
   output logic       zera_jogada,
   output logic       timer_restart,
   output logic       timer_animacao_restart,
   output logic       conta_timer_animacao,
   output logic       zera_erro,
   output logic       conta_erro,
   output logic       mapa_fim,
   output logic       pronto,
   output logic       ganhou,
   output logic       perdeu,
   output logic [3:0] db_estado
);

   localparam logic [3:0] c_INICIAL      = 4'd0;
   localparam logic [3:0] c_PREPARA      = 4'd1;
   localparam logic [3:0] c_AGUARDA_ROM  = 4'd2;
   localparam logic [3:0] c_CARREGA      = 4'd3;
   localparam logic [3:0] c_ESPERA       = 4'd4;
   localparam logic [3:0] c_REGISTRA     = 4'd5;
   localparam logic [3:0] c_COMPARA      = 4'd6;
   localparam logic [3:0] c_ANIMA_ACERTO = 4'd7;
   localparam logic [3:0] c_PROXIMA      = 4'd8;
   localparam logic [3:0] c_CONTA_ERRO   = 4'd9;
   localparam logic [3:0] c_ANIMA_ERRO   = 4'd10;
   localparam logic [3:0] c_FIM_GANHOU   = 4'd11;
   localparam logic [3:0] c_FIM_PERDEU   = 4'd12;

   localparam logic [3:0] c_MAX_ERROS = 4'(MAX_ERROS);

   logic [3:0] r_estado;
   logic [3:0] w_proximo;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) r_estado <= c_INICIAL;
      else       r_estado <= w_proximo;
   end

   always_comb begin
      w_proximo = c_INICIAL;
      case (r_estado)
         c_INICIAL:      w_proximo = iniciar ? c_PREPARA : c_INICIAL;
         c_PREPARA:      w_proximo = c_AGUARDA_ROM;
         c_AGUARDA_ROM:  w_proximo = c_CARREGA;
         c_CARREGA:      w_proximo = c_ESPERA;
         // timeout outranks a press arriving in the same cycle
         c_ESPERA: begin
            if (timeout)         w_proximo = c_CONTA_ERRO;
            else if (tem_jogada) w_proximo = c_REGISTRA;
            else                 w_proximo = c_ESPERA;
         end
         c_REGISTRA:     w_proximo = c_COMPARA;
         c_COMPARA:      w_proximo = jogada_ok ? c_ANIMA_ACERTO : c_CONTA_ERRO;
         c_ANIMA_ACERTO: begin
            if (!fim_timer_animacao) w_proximo = c_ANIMA_ACERTO;
            else if (fim_sequencia)  w_proximo = c_FIM_GANHOU;
            else                     w_proximo = c_PROXIMA;
         end
         c_PROXIMA:      w_proximo = c_AGUARDA_ROM;
         c_CONTA_ERRO:   w_proximo = c_ANIMA_ERRO;
         // a failed move retries the same address, so reload without incrementing
         c_ANIMA_ERRO: begin
            if (!fim_timer_animacao)                    w_proximo = c_ANIMA_ERRO;
            else if ((erros >= c_MAX_ERROS) || fim_erro) w_proximo = c_FIM_PERDEU;
            else                                        w_proximo = c_CARREGA;
         end
         c_FIM_GANHOU:   w_proximo = iniciar ? c_PREPARA : c_FIM_GANHOU;
         c_FIM_PERDEU:   w_proximo = iniciar ? c_PREPARA : c_FIM_PERDEU;
         default:        w_proximo = c_INICIAL;
      endcase
   end

   always_comb begin
      zera_contador          = 1'b0;
      conta_contador         = 1'b0;
      enable_memoria         = 1'b0;
      registra_jogada        = 1'b0;
      zera_jogada            = 1'b0;
      timer_restart          = 1'b0;
      timer_animacao_restart = 1'b0;
      conta_timer_animacao   = 1'b0;
      zera_erro              = 1'b0;
      conta_erro             = 1'b0;
      mapa_fim               = 1'b0;
      pronto                 = 1'b0;
      ganhou                 = 1'b0;
      perdeu                 = 1'b0;
      db_estado              = r_estado;
      case (r_estado)
         c_INICIAL: pronto = 1'b1;
         c_PREPARA: begin
            zera_contador          = 1'b1;
            zera_erro              = 1'b1;
            zera_jogada            = 1'b1;
            timer_restart          = 1'b1;
            timer_animacao_restart = 1'b1;
         end
         c_CARREGA: begin
            enable_memoria = 1'b1;
            timer_restart  = 1'b1;
         end
         c_REGISTRA:     registra_jogada        = 1'b1;
         c_COMPARA:      timer_animacao_restart = 1'b1;
         c_ANIMA_ACERTO: conta_timer_animacao   = 1'b1;
         c_PROXIMA: begin
            conta_contador = 1'b1;
            zera_jogada    = 1'b1;
         end
         c_CONTA_ERRO: begin
            conta_erro             = 1'b1;
            zera_jogada            = 1'b1;
            timer_animacao_restart = 1'b1;
         end
         c_ANIMA_ERRO: conta_timer_animacao = 1'b1;
         c_FIM_GANHOU: begin
            mapa_fim       = 1'b1;
            enable_memoria = 1'b1;
            ganhou         = 1'b1;
         end
         c_FIM_PERDEU: begin
            mapa_fim       = 1'b1;
            enable_memoria = 1'b1;
            perdeu         = 1'b1;
         end
         default: ;
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_teatris_unidade_controle.sv
`default_nettype none
// ============================================================================
// Module  : tb_teatris_unidade_controle
// Purpose : Directed self-checking bench for the TEAtris control unit.
// Rev     : 1.0  initial release
// ============================================================================
module tb_teatris_unidade_controle;

   logic       clock = 1'b0;
   logic       reset, iniciar, tem_jogada, jogada_ok, fim_sequencia;
   logic       timeout, fim_timer_animacao, fim_erro;
   logic [3:0] erros;
   logic       zera_contador, conta_contador, enable_memoria, registra_jogada;
   logic       zera_jogada, timer_restart, timer_animacao_restart, conta_timer_animacao;
   logic       zera_erro, conta_erro, mapa_fim, pronto, ganhou, perdeu;
   logic [3:0] db_estado;

   int n_pass  = 0;
   int n_total = 0;
   int n_cc    = 0;
   int n_ce    = 0;

   localparam logic [13:0] ZC  = 14'h2000;
   localparam logic [13:0] CC  = 14'h1000;
   localparam logic [13:0] EM  = 14'h0800;
   localparam logic [13:0] RJ  = 14'h0400;
   localparam logic [13:0] ZJ  = 14'h0200;
   localparam logic [13:0] TR  = 14'h0100;
   localparam logic [13:0] TAR = 14'h0080;
   localparam logic [13:0] CTA = 14'h0040;
   localparam logic [13:0] ZE  = 14'h0020;
   localparam logic [13:0] CE  = 14'h0010;
   localparam logic [13:0] MF  = 14'h0008;
   localparam logic [13:0] PR  = 14'h0004;
   localparam logic [13:0] GA  = 14'h0002;
   localparam logic [13:0] PE  = 14'h0001;
   localparam logic [13:0] NONE = 14'h0000;

   logic [13:0] w_outs;
   assign w_outs = {zera_contador, conta_contador, enable_memoria, registra_jogada,
                    zera_jogada, timer_restart, timer_animacao_restart, conta_timer_animacao,
                    zera_erro, conta_erro, mapa_fim, pronto, ganhou, perdeu};

   teatris_unidade_controle #(.MAX_ERROS(3)) dut (
      .clock                  (clock),
      .reset                  (reset),
      .iniciar                (iniciar),
      .tem_jogada             (tem_jogada),
      .jogada_ok              (jogada_ok),
      .fim_sequencia          (fim_sequencia),
      .timeout                (timeout),
      .fim_timer_animacao     (fim_timer_animacao),
      .fim_erro               (fim_erro),
      .erros                  (erros),
      .zera_contador          (zera_contador),
      .conta_contador         (conta_contador),
      .enable_memoria         (enable_memoria),
      .registra_jogada        (registra_jogada),
      .zera_jogada            (zera_jogada),
      .timer_restart          (timer_restart),
      .timer_animacao_restart (timer_animacao_restart),
      .conta_timer_animacao   (conta_timer_animacao),
      .zera_erro              (zera_erro),
      .conta_erro             (conta_erro),
      .mapa_fim               (mapa_fim),
      .pronto                 (pronto),
      .ganhou                 (ganhou),
      .perdeu                 (perdeu),
      .db_estado              (db_estado)
   );

   always #5 clock = ~clock;

   // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge clock);
      #1;
      if (conta_contador) n_cc++;
      if (conta_erro)     n_ce++;
   endtask

   task automatic test_reset();
      reset = 1'b1; iniciar = 1'b0; tem_jogada = 1'b0; jogada_ok = 1'b0;
      fim_sequencia = 1'b0; timeout = 1'b0; fim_timer_animacao = 1'b0;
      fim_erro = 1'b0; erros = 4'd0;
      #12;
      n_total++;
      if (db_estado !== 4'd0 || w_outs !== PR)
         $display("FAIL reset_state: estado=%0d outs=%b required estado=0 outs=%b", db_estado, w_outs, PR);
      else n_pass++;
      @(posedge clock); #1; reset = 1'b0;
      tick();
      n_total++;
      if (db_estado !== 4'd0 || w_outs !== PR)
         $display("FAIL idle_hold: estado=%0d outs=%b required estado=0 outs=%b", db_estado, w_outs, PR);
      else n_pass++;
   endtask

   task automatic test_start();
      iniciar = 1'b1;
      tick();
      iniciar = 1'b0;
      n_total++;
      if (db_estado !== 4'd1 || w_outs !== (ZC | ZE | ZJ | TR | TAR))
         $display("FAIL start_prepara: estado=%0d outs=%b required estado=1 outs=%b", db_estado, w_outs, ZC | ZE | ZJ | TR | TAR);
      else n_pass++;
      tick();
      n_total++;
      if (db_estado !== 4'd2 || w_outs !== NONE)
         $display("FAIL start_rom: estado=%0d outs=%b required estado=2 outs=%b", db_estado, w_outs, NONE);
      else n_pass++;
      tick();
      n_total++;
      if (db_estado !== 4'd3 || w_outs !== (EM | TR))
         $display("FAIL start_carrega: estado=%0d outs=%b required estado=3 outs=%b", db_estado, w_outs, EM | TR);
      else n_pass++;
      tick();
      n_total++;
      if (db_estado !== 4'd4 || w_outs !== NONE)
         $display("FAIL start_espera: estado=%0d outs=%b required estado=4 outs=%b", db_estado, w_outs, NONE);
      else n_pass++;
   endtask

   task automatic test_ignore_in_espera();
      iniciar = 1'b1; fim_timer_animacao = 1'b1; jogada_ok = 1'b1;
      tick(); tick();
      iniciar = 1'b0; fim_timer_animacao = 1'b0; jogada_ok = 1'b0;
      n_total++;
      if (db_estado !== 4'd4)
         $display("FAIL espera_ignores: estado=%0d required 4", db_estado);
      else n_pass++;
   endtask

   task automatic test_acerto();
      n_cc = 0;
      jogada_ok = 1'b1; fim_sequencia = 1'b0; tem_jogada = 1'b1;
      tick();
      tem_jogada = 1'b0;
      n_total++;
      if (db_estado !== 4'd5 || w_outs !== RJ)
         $display("FAIL acerto_registra: estado=%0d outs=%b required estado=5 outs=%b", db_estado, w_outs, RJ);
      else n_pass++;
      tick();
      n_total++;
      if (db_estado !== 4'd6 || w_outs !== TAR)
         $display("FAIL acerto_compara: estado=%0d outs=%b required estado=6 outs=%b", db_estado, w_outs, TAR);
      else n_pass++;
      tick();
      jogada_ok = 1'b0;
      timeout = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      timeout = 1'b0;
      n_total++;
      if (db_estado !== 4'd7 || w_outs !== CTA)
         $display("FAIL acerto_anima_hold: estado=%0d outs=%b required estado=7 outs=%b", db_estado, w_outs, CTA);
      else n_pass++;
      fim_timer_animacao = 1'b1;
      tick();
      fim_timer_animacao = 1'b0;
      n_total++;
      if (db_estado !== 4'd8 || w_outs !== (CC | ZJ))
         $display("FAIL acerto_proxima: estado=%0d outs=%b required estado=8 outs=%b", db_estado, w_outs, CC | ZJ);
      else n_pass++;
      tick(); tick();
      n_total++;
      if (db_estado !== 4'd3)
         $display("FAIL acerto_reload: estado=%0d required 3", db_estado);
      else n_pass++;
      tick();
      n_total++;
      if (db_estado !== 4'd4 || n_cc !== 1)
         $display("FAIL acerto_conta_once: estado=%0d conta_contador_cycles=%0d required estado=4 cycles=1", db_estado, n_cc);
      else n_pass++;
   endtask

   task automatic test_erro_retry();
      n_cc = 0; n_ce = 0;
      jogada_ok = 1'b0; tem_jogada = 1'b1;
      tick();
      tem_jogada = 1'b0;
      tick();
      n_total++;
      if (db_estado !== 4'd6)
         $display("FAIL erro_compara: estado=%0d required 6", db_estado);
      else n_pass++;
      tick();
      n_total++;
      if (db_estado !== 4'd9 || w_outs !== (CE | ZJ | TAR))
         $display("FAIL erro_conta: estado=%0d outs=%b required estado=9 outs=%b", db_estado, w_outs, CE | ZJ | TAR);
      else n_pass++;
      erros = 4'd1;
      tick();
      n_total++;
      if (db_estado !== 4'd10 || w_outs !== CTA)
         $display("FAIL erro_anima: estado=%0d outs=%b required estado=10 outs=%b", db_estado, w_outs, CTA);
      else n_pass++;
      fim_timer_animacao = 1'b1;
      tick();
      fim_timer_animacao = 1'b0;
      n_total++;
      if (db_estado !== 4'd3)
         $display("FAIL erro_retry_carrega: estado=%0d required 3", db_estado);
      else n_pass++;
      tick();
      n_total++;
      if (db_estado !== 4'd4 || n_ce !== 1 || n_cc !== 0)
         $display("FAIL erro_counts: estado=%0d conta_erro=%0d conta_contador=%0d required 4/1/0", db_estado, n_ce, n_cc);
      else n_pass++;
   endtask

   task automatic test_timeout_and_loss();
      erros = 4'd2; timeout = 1'b1; tem_jogada = 1'b1;
      tick();
      timeout = 1'b0; tem_jogada = 1'b0;
      n_total++;
      if (db_estado !== 4'd9)
         $display("FAIL timeout_priority: estado=%0d required 9", db_estado);
      else n_pass++;
      tick();
      fim_timer_animacao = 1'b1;
      tick();
      fim_timer_animacao = 1'b0;
      n_total++;
      if (db_estado !== 4'd3)
         $display("FAIL erros_below_max: estado=%0d required 3", db_estado);
      else n_pass++;
      tick();
      timeout = 1'b1;
      tick(); tick();
      timeout = 1'b0;
      erros = 4'd3;
      tick();
      n_total++;
      if (db_estado !== 4'd10)
         $display("FAIL loss_wait_anim: estado=%0d required 10", db_estado);
      else n_pass++;
      fim_timer_animacao = 1'b1;
      tick();
      fim_timer_animacao = 1'b0;
      n_total++;
      if (db_estado !== 4'd12 || w_outs !== (MF | EM | PE))
         $display("FAIL loss_state: estado=%0d outs=%b required estado=12 outs=%b", db_estado, w_outs, MF | EM | PE);
      else n_pass++;
      tick();
      n_total++;
      if (db_estado !== 4'd12)
         $display("FAIL loss_hold: estado=%0d required 12", db_estado);
      else n_pass++;
      iniciar = 1'b1;
      tick();
      iniciar = 1'b0;
      n_total++;
      if (db_estado !== 4'd1)
         $display("FAIL loss_restart: estado=%0d required 1", db_estado);
      else n_pass++;
      erros = 4'd0;
      tick(); tick(); tick();
   endtask

   task automatic test_fim_erro();
      erros = 4'd0; fim_erro = 1'b1; timeout = 1'b1;
      tick();
      timeout = 1'b0;
      tick();
      fim_timer_animacao = 1'b1;
      tick();
      fim_timer_animacao = 1'b0; fim_erro = 1'b0;
      n_total++;
      if (db_estado !== 4'd12)
         $display("FAIL fim_erro_loss: estado=%0d required 12", db_estado);
      else n_pass++;
      iniciar = 1'b1;
      tick();
      iniciar = 1'b0;
      tick(); tick(); tick();
   endtask

   task automatic test_win();
      jogada_ok = 1'b1; tem_jogada = 1'b1;
      tick();
      tem_jogada = 1'b0;
      tick(); tick();
      jogada_ok = 1'b0;
      fim_sequencia = 1'b1; fim_timer_animacao = 1'b1;
      tick();
      fim_timer_animacao = 1'b0;
      n_total++;
      if (db_estado !== 4'd11 || w_outs !== (MF | EM | GA))
         $display("FAIL win_state: estado=%0d outs=%b required estado=11 outs=%b", db_estado, w_outs, MF | EM | GA);
      else n_pass++;
      fim_sequencia = 1'b0;
      iniciar = 1'b1;
      tick();
      iniciar = 1'b0;
      n_total++;
      if (db_estado !== 4'd1)
         $display("FAIL win_restart: estado=%0d required 1", db_estado);
      else n_pass++;
      tick(); tick(); tick();
   endtask

   task automatic test_async_reset();
      timeout = 1'b1;
      tick();
      timeout = 1'b0;
      tick();
      n_total++;
      if (db_estado !== 4'd10)
         $display("FAIL areset_setup: estado=%0d required 10", db_estado);
      else n_pass++;
      #2 reset = 1'b1;
      #1;
      n_total++;
      if (db_estado !== 4'd0 || w_outs !== PR)
         $display("FAIL areset_immediate: estado=%0d outs=%b required estado=0 outs=%b", db_estado, w_outs, PR);
      else n_pass++;
      #1 reset = 1'b0;
      tick();
      n_total++;
      if (db_estado !== 4'd0 || pronto !== 1'b1)
         $display("FAIL areset_after: estado=%0d pronto=%b required estado=0 pronto=1", db_estado, pronto);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_start();
      test_ignore_in_espera();
      test_acerto();
      test_erro_retry();
      test_timeout_and_loss();
      test_fim_erro();
      test_win();
      test_async_reset();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
